decode_stage: RTL

Registered, handshaked RV32 decode stage that sits between fetch and execute. It turns a 32-bit instruction plus its PC into a control bundle: register write/memory write/branch/jump flags, ALU code, register indices and sign-extended immediate. It also flags illegal encodings. A 2-entry output buffer decouples fetch from execute back-pressure, so the stage sustains one instruction per cycle.

---
 rtl/decode_pkg.sv | 110 +++++++++++
 rtl/decode_comb.sv | 141 ++++++++++++++
 rtl/decode_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode classes, ALU operation codes, the XLEN-free
// control bundle and immediate-format helpers.
package decode_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_code_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // PC and immediate are XLEN wide, so the full bundle typedef lives in the module.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    alu_code_e  alu_code;
    logic       alu_src_imm;
    logic       write_reg;
    logic       write_ram;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  function automatic alu_code_e base_alu(input logic [2:0] funct3, input logic arith);
    alu_code_e code;
    case (funct3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = arith ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  function automatic alu_code_e muldiv_alu(input logic [2:0] funct3);
    alu_code_e code;
    case (funct3)
      3'b000:  code = ALU_MUL;
      3'b001:  code = ALU_MULH;
      3'b010:  code = ALU_MULHSU;
      3'b011:  code = ALU_MULHU;
      3'b100:  code = ALU_DIV;
      3'b101:  code = ALU_DIVU;
      3'b110:  code = ALU_REM;
      3'b111:  code = ALU_REMU;
      default: code = ALU_MUL;
    endcase
    return code;
  endfunction

  function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32 instruction -> control bundle decoder.
// Define DECODE_M_EXT_EN to accept the M-extension multiply/divide encodings.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [4:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  alu_code_e   alu_s;
  imm_fmt_e    fmt_s;
  logic        legal_s;
  logic        illegal_s;
  logic        wr_class_s;
  logic        ram_s;
  logic        br_s;
  logic        jmp_s;
  logic        src_imm_s;
  logic [31:0] imm32_s;

  assign opc_s = instr_i[6:2];
  assign f3_s  = instr_i[14:12];
  assign f7_s  = instr_i[31:25];

  // Class decode: ALU code, immediate format, class flags and encoding legality.
  always_comb begin
    legal_s    = 1'b1;
    alu_s      = ALU_ADD;
    fmt_s      = IMM_NONE;
    wr_class_s = 1'b0;
    ram_s      = 1'b0;
    br_s       = 1'b0;
    jmp_s      = 1'b0;
    src_imm_s  = 1'b1;
    case (opc_s)
      OPC_LUI: begin
        fmt_s      = IMM_U;
        alu_s      = ALU_PASSB;
        wr_class_s = 1'b1;
      end
      OPC_AUIPC: begin
        fmt_s      = IMM_U;
        wr_class_s = 1'b1;
      end
      OPC_OPIMM: begin
        fmt_s      = IMM_I;
        wr_class_s = 1'b1;
        alu_s      = base_alu(f3_s, f7_s == F7_ALT);
        // Shift immediates reuse funct7; everything else treats it as immediate bits.
        if (f3_s == 3'b001) begin
          legal_s = (f7_s == F7_ZERO);
        end else if (f3_s == 3'b101) begin
          legal_s = (f7_s == F7_ZERO) || (f7_s == F7_ALT);
        end else begin
          legal_s = 1'b1;
        end
      end
      OPC_OP: begin
        wr_class_s = 1'b1;
        src_imm_s  = 1'b0;
        if (f7_s == F7_ZERO) begin
          alu_s = base_alu(f3_s, 1'b0);
        end else if (f7_s == F7_ALT) begin
          if (f3_s == 3'b000) begin
            alu_s = ALU_SUB;
          end else if (f3_s == 3'b101) begin
            alu_s = ALU_SRA;
          end else begin
            legal_s = 1'b0;
          end
        end else if (f7_s == F7_MULDIV) begin
`ifdef DECODE_M_EXT_EN
          alu_s = muldiv_alu(f3_s);
`else
          legal_s = 1'b0;
`endif
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_LOAD: begin
        fmt_s      = IMM_I;
        wr_class_s = 1'b1;
        legal_s    = (f3_s != 3'b011) && (f3_s != 3'b110) && (f3_s != 3'b111);
      end
      OPC_STORE: begin
        fmt_s   = IMM_S;
        ram_s   = 1'b1;
        legal_s = (f3_s < 3'b011);
      end
      OPC_JAL: begin
        fmt_s      = IMM_J;
        wr_class_s = 1'b1;
        jmp_s      = 1'b1;
      end
      OPC_JALR: begin
        fmt_s      = IMM_I;
        wr_class_s = 1'b1;
        jmp_s      = 1'b1;
        legal_s    = (f3_s == 3'b000);
      end
      OPC_BRANCH: begin
        fmt_s     = IMM_B;
        br_s      = 1'b1;
        src_imm_s = 1'b0;
        alu_s     = ALU_SUB;
        legal_s   = (f3_s != 3'b010) && (f3_s != 3'b011);
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  assign illegal_s = !legal_s || (instr_i[1:0] != 2'b11);
  assign imm32_s   = imm32(instr_i, fmt_s);
  assign imm_o     = XLEN'(signed'(imm32_s));

  // Bundle assembly; illegal entries carry no side-effecting flags.
  always_comb begin
    ctrl_o             = '0;
    ctrl_o.rd          = instr_i[11:7];
    ctrl_o.rs1         = instr_i[19:15];
    ctrl_o.rs2         = instr_i[24:20];
    ctrl_o.funct3      = f3_s;
    ctrl_o.alu_code    = alu_s;
    ctrl_o.alu_src_imm = src_imm_s;
    ctrl_o.illegal     = illegal_s;
    ctrl_o.write_reg   = wr_class_s && (instr_i[11:7] != 5'd0) && !illegal_s;
    ctrl_o.write_ram   = ram_s && !illegal_s;
    ctrl_o.branch      = br_s && !illegal_s;
    ctrl_o.jump        = jmp_s && !illegal_s;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32 decode stage with a 2-entry output buffer.
// Define DECODE_M_EXT_EN to decode M-extension instructions.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_aluCode,
  output logic            out_aluSrcImm,
  output logic            out_writeReg,
  output logic            out_writeRam,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
  } bundle_t;

  bundle_t         new_s;
  bundle_t         head_q, head_d;
  bundle_t         tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic            push_s;
  logic            pop_s;
  ctrl_t           ctrl_s;
  logic [XLEN-1:0] imm_s;

  decode_comb #(
    .XLEN (XLEN)
  ) u_decode_comb (
    .instr_i (in_instr),
    .ctrl_o  (ctrl_s),
    .imm_o   (imm_s)
  );

  assign new_s.pc   = in_pc;
  assign new_s.imm  = imm_s;
  assign new_s.ctrl = ctrl_s;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Buffer next state: head is always slot 0, so the outputs come straight from a register.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = new_s;
          end else begin
            tail_d = new_s;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Push needs count < 2 and pop needs count > 0, so count is 1 here.
          head_d = new_s;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_pc        = head_q.pc;
  assign out_imm       = head_q.imm;
  assign out_rd        = head_q.ctrl.rd;
  assign out_rs1       = head_q.ctrl.rs1;
  assign out_rs2       = head_q.ctrl.rs2;
  assign out_funct3    = head_q.ctrl.funct3;
  assign out_aluCode   = head_q.ctrl.alu_code;
  assign out_aluSrcImm = head_q.ctrl.alu_src_imm;
  assign out_writeReg  = head_q.ctrl.write_reg;
  assign out_writeRam  = head_q.ctrl.write_ram;
  assign out_branch    = head_q.ctrl.branch;
  assign out_jump      = head_q.ctrl.jump;
  assign out_illegal   = head_q.ctrl.illegal;

endmodule
